mem_block_read_streamer: RTL and testbench

Read-side sequencer for the `dual_port_ram`-based memory blocks: on a start command it sweeps a contiguous address range over the RAM read port and delivers each word on a valid/ready stream. It absorbs the RAM's fixed 1-cycle read latency and downstream backpressure without losing or duplicating words. One instance sits between each image or kernel memory bank and the consumer that drains it (pointwise multiply / inverse-FFT stage).

---
 rtl/mem_block_read_streamer_pkg.sv | 26 ++
 rtl/mem_block_read_streamer_if.sv | 32 +++
 rtl/mem_block_read_streamer_skid_fifo2.sv | 58 +++++
 rtl/mem_block_read_streamer.sv | 116 +++++++++++
 tb/tb_mem_block_read_streamer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_block_read_streamer_pkg.sv
// Shared definitions for the memory-block read streamer: complex word layout
// and the issue-admission rule that keeps the 2-entry output buffer safe.
package mem_block_read_streamer_pkg;

  // One RAM word carries one complex sample: real half on top, imag below.
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  localparam int REAL_MSB      = 63;
  localparam int IMAG_LSB      = 0;
  localparam int COMPLEX_WIDTH = $bits(complex_t);

  // A new read may be issued only if the words already owned by the buffer
  // (stored plus returning this cycle, minus the one leaving this cycle)
  // leave room for the word that the new read will return next cycle.
  function automatic logic issue_allowed(input logic [1:0] occupancy,
                                         input logic       inflight,
                                         input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, occupancy} + {2'b00, inflight};
    return pending < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/mem_block_read_streamer_if.sv
// Command, RAM read port and output stream signals of one read streamer.
// The master modport is the streamer; the slave modport is its surroundings
// (command source, RAM and downstream consumer).
interface mem_block_read_streamer_if
  import mem_block_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = COMPLEX_WIDTH,
  parameter int ADDR_WIDTH = 13
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_address;
  logic [ADDR_WIDTH:0]   length;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_address, length, ram_data, out_ready,
    output read_address, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_address, length, ram_data, out_ready,
    input  read_address, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/mem_block_read_streamer_skid_fifo2.sv
// Two-entry FIFO used as the output buffer of the read streamer. Push into a
// full FIFO and pop from an empty one are ignored; entries reset to zero so
// the head reads as zero out of reset.
module skid_fifo2
  import mem_block_read_streamer_pkg::*;
#(
  parameter int WIDTH = COMPLEX_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entries [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fill;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (fill != 2'd2);
  assign do_pop   = pop && (fill != 2'd0);
  assign pop_data = entries[rd_ptr];
  assign full     = (fill == 2'd2);
  assign empty    = (fill == 2'd0);
  assign count    = fill;

  // Storage, pointers and fill level; simultaneous push and pop keep the fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries[0] <= '0;
      entries[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fill       <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/mem_block_read_streamer.sv
// Read-side sequencer for a dual-port RAM bank: sweeps a contiguous address
// range over the RAM read port and streams each word out on valid/ready,
// absorbing the RAM's 1-cycle read latency and downstream backpressure.
module mem_block_read_streamer
  import mem_block_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = COMPLEX_WIDTH,
  parameter int ADDR_WIDTH = 13
) (
  input logic                      clk,
  input logic                      reset,
  mem_block_read_streamer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] address;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  done_reg;
  logic                  done_next;
  logic                  load;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign pop  = !fifo_empty && bus.out_ready;
  assign push = inflight && !fifo_full;

  assign bus.read_address = address;
  assign bus.out_data     = fifo_head;
  assign bus.out_valid    = !fifo_empty;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_reg;

  skid_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.ram_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next state, read issue and completion; the drain exit looks at this
  // cycle's pop so done lands right after the final handshake edge.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            load       = 1'b1;
            state_next = STREAM;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      STREAM: begin
        issue = (remaining != '0) && issue_allowed(fifo_count, inflight, pop);
        if (issue && (remaining == (ADDR_WIDTH+1)'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && (fifo_empty || ((fifo_count == 2'd1) && pop))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, address/remaining counters, in-flight marker and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      address   <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      done_reg <= done_next;
      inflight <= issue;
      if (load) begin
        address   <= bus.base_address;
        remaining <= bus.length;
      end else if (issue) begin
        address   <= address + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_block_read_streamer.sv
// Bench for mem_block_read_streamer with a 9-bit (kernel bank) address space.
// A behavioural RAM returns words one cycle after the address; the reference
// model is a queue of the words expected for each command.
module tb_mem_block_read_streamer
  import mem_block_read_streamer_pkg::*;
;

  localparam int AW    = 9;
  localparam int DW    = COMPLEX_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  logic [REAL_MSB:IMAG_LSB] mem [DEPTH];

  mem_block_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_block_read_streamer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // RAM read port with its fixed 1-cycle latency and no read enable.
  always @(posedge clk) begin
    bus.ram_data <= mem[bus.read_address];
  end

  function automatic logic [REAL_MSB:IMAG_LSB] ram_word(input logic [AW-1:0] a);
    complex_t w;
    w.re = {23'h0, a};
    w.im = 32'hC0DE_0000 ^ {23'h0, a};
    return w;
  endfunction

  function automatic logic pick_ready(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_read_address"}, 64'(bus.read_address), 64'd0);
    check({tag, "_out_data"},     64'(bus.out_data),     64'd0);
    check({tag, "_out_valid"},    64'(bus.out_valid),    64'd0);
    check({tag, "_busy"},         64'(bus.busy),         64'd0);
    check({tag, "_done"},         64'(bus.done),         64'd0);
  endtask

  // Issue one command and follow it to completion (or to a reset after
  // abort_after accepted words). Every cycle checks done/busy, the address
  // lead over accepted words, and the head word against the model.
  task automatic run_stream(input logic [AW-1:0] base, input logic [AW:0] len,
                            input int ready_pct, input bit poke_start, input int abort_after);
    logic [63:0]   expq [$];
    logic [AW-1:0] a;
    logic [AW-1:0] off;
    int            idx;
    int            accepted;
    int            limit;
    bit            first_seen;
    bit            final_pending;
    bit            finished;
    for (int i = 0; i < int'(len); i++) begin
      a = base + AW'(i);
      expq.push_back(mem[a]);
    end
    limit            = 20 * int'(len) + 50;
    bus.start        = 1'b1;
    bus.base_address = base;
    bus.length       = len;
    bus.out_ready    = pick_ready(ready_pct);
    step();
    bus.start        = 1'b0;
    bus.base_address = AW'($urandom);
    bus.length       = (AW+1)'($urandom);
    idx              = 1;
    accepted         = 0;
    first_seen       = 1'b0;
    final_pending    = 1'b0;
    finished         = 1'b0;
    while (!finished) begin
      if (idx > limit) begin
        check("timeout", 64'd0, 64'd1);
        finished = 1'b1;
      end else begin
        check("done", 64'(bus.done), 64'(final_pending || (len == '0 && idx == 1)));
        if (final_pending || len == '0) begin
          check("busy_at_done",  64'(bus.busy),      64'd0);
          check("valid_at_done", 64'(bus.out_valid), 64'd0);
          finished = 1'b1;
        end else begin
          check("busy", 64'(bus.busy), 64'd1);
          off = bus.read_address - base;
          check("addr_lead", 64'(int'(off) >= accepted && int'(off) <= accepted + 2
                                 && int'(off) <= int'(len)), 64'd1);
          if (bus.out_valid && !first_seen) begin
            first_seen = 1'b1;
            check("first_valid_cycle", 64'(idx), 64'd3);
          end
          if (abort_after >= 0 && accepted == abort_after) begin
            reset = 1'b1;
            step();
            check_reset_values("mid_reset");
            reset    = 1'b0;
            finished = 1'b1;
          end else begin
            bus.start = poke_start && (idx == 4);
            if (bus.start) begin
              bus.base_address = AW'($urandom);
              bus.length       = (AW+1)'($urandom_range(40, 1));
            end
            bus.out_ready = pick_ready(ready_pct);
            if (bus.out_valid) begin
              if (expq.size() == 0) begin
                check("extra_word", 64'd1, 64'd0);
              end else begin
                check("data", bus.out_data, expq[0]);
                if (bus.out_ready) begin
                  void'(expq.pop_front());
                  accepted++;
                  if (expq.size() == 0) final_pending = 1'b1;
                end
              end
            end
            step();
            idx++;
          end
        end
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = ram_word(AW'(i));
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.base_address = '0;
    bus.length       = '0;
    bus.out_ready    = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b0;
    step();

    $display("[TB] basic stream");
    run_stream(9'h010, 10'd8, 100, 1'b0, -1);

    $display("[TB] backpressure");
    run_stream(AW'($urandom), 10'd16, 50, 1'b0, -1);

    $display("[TB] wrap-around");
    run_stream(9'h1FE, 10'd4, 100, 1'b0, -1);
    run_stream(9'h1FE, 10'd4, 50, 1'b0, -1);

    $display("[TB] zero length");
    run_stream(9'h055, 10'd0, 100, 1'b0, -1);
    step();
    check("zero_len_done_pulse", 64'(bus.done),      64'd0);
    check("zero_len_busy",       64'(bus.busy),      64'd0);
    check("zero_len_valid",      64'(bus.out_valid), 64'd0);

    $display("[TB] start while busy");
    run_stream(9'h0A0, 10'd12, 70, 1'b1, -1);

    $display("[TB] reset mid-stream");
    run_stream(9'h040, 10'd10, 100, 1'b0, 3);
    run_stream(9'h123, 10'd2, 100, 1'b0, -1);

    $display("[TB] random commands");
    for (int n = 0; n < 6; n++) begin
      run_stream(AW'($urandom), (AW+1)'($urandom_range(40, 1)),
                 int'($urandom_range(100, 30)), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
